virtio_vq_event_arb: RTL

Synthesizable, parametrised tracker for virtqueue events between the device-side worker threads of the virtio FPGA shell (notify → available-ring fetch → used-ring write-back). Keeps one pending flag per (stage, queue), coalesces repeated events, and arbitrates pending queues round-robin to each stage's consumer over a valid/ready handshake. Also holds each queue's driver `avail.idx` shadow and the device `next_avail_idx`, flagging outstanding work and ring-index overrun. Sits beside `virtio_csr` in `FIU.feature_ram`, on the same `clk`.

---
 rtl/virtio_vq_pkg.sv | 13 +
 rtl/virtio_vq_event_arb_rr_arb.sv | 55 +++++
 rtl/virtio_vq_event_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/virtio_vq_pkg.sv
// virtio_vq_pkg: shared stage ids, default widths and queue-id type for the virtqueue event tracker
package virtio_vq_pkg;
  localparam int STG_NOTIFY = 0;
  localparam int STG_AVAIL = 1;
  localparam int STG_USED = 2;
  localparam int DEF_NUM_QUEUES = 3;
  localparam int DEF_NUM_STAGES = 3;
  localparam int DEF_IDX_W = 16;
  localparam int DEF_Q_SIZE = 256;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_QID_W = (DEF_NUM_QUEUES > 1) ? $clog2(DEF_NUM_QUEUES) : 1;
  typedef logic [DEF_QID_W-1:0] qid_t;
endpackage

// File: rtl/virtio_vq_event_arb_rr_arb.sv
// vq_rr_arb: one stage's output slot, fed round-robin from the next-state pending flags
module vq_rr_arb #(
  parameter int NQ = 3,
  parameter int QW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soft_clr,
  input  logic [NQ-1:0] pend_nxt_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [QW-1:0] qid_o
);
  logic          valid_q, valid_d, hs;
  logic [QW-1:0] qid_q, qid_d, rr_ptr_q, rr_ptr_d;
  int            j;
  assign hs = valid_q & ready_i;
  assign valid_o = valid_q;
  assign qid_o = qid_q;
  // advance the pointer past an accepted queue and reload the slot when it frees up
  always_comb begin
    rr_ptr_d = hs ? ((qid_q == QW'(NQ-1)) ? '0 : qid_q + QW'(1)) : rr_ptr_q;
    valid_d = valid_q;
    qid_d = qid_q;
    j = 0;
    if (!valid_q || hs) begin
      valid_d = 1'b0;
      qid_d = '0;
      for (int i = NQ-1; i >= 0; i--) begin
        j = int'(rr_ptr_d) + i;
        if (j >= NQ) j -= NQ;
        if (pend_nxt_i[j]) begin
          valid_d = 1'b1;
          qid_d = QW'(j);
        end
      end
    end
  end
  // slot and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      qid_q <= '0;
      rr_ptr_q <= '0;
    end else if (soft_clr) begin
      valid_q <= 1'b0;
      qid_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      qid_q <= qid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: rtl/virtio_vq_event_arb.sv
// virtio_vq_event_arb: per-(stage,queue) pending flags with coalescing, round-robin event arbitration and ring-index tracking
module virtio_vq_event_arb import virtio_vq_pkg::*; #(
  parameter int NUM_QUEUES = DEF_NUM_QUEUES,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int QID_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  parameter int IDX_W = DEF_IDX_W,
  parameter int Q_SIZE = DEF_Q_SIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             csr_rst_n,
  input  logic                             soft_clr,
  input  logic [NUM_STAGES*NUM_QUEUES-1:0] set_i,
  output logic [NUM_STAGES-1:0]            evt_valid_o,
  output logic [NUM_STAGES*QID_W-1:0]      evt_qid_o,
  input  logic [NUM_STAGES-1:0]            evt_ready_i,
  output logic [NUM_STAGES*NUM_QUEUES-1:0] pending_o,
  output logic [NUM_STAGES*CNT_W-1:0]      coalesce_cnt_o,
  input  logic                             avail_idx_we_i,
  input  logic [QID_W-1:0]                 avail_idx_qid_i,
  input  logic [IDX_W-1:0]                 avail_idx_i,
  input  logic                             consume_i,
  input  logic [QID_W-1:0]                 consume_qid_i,
  output logic [NUM_QUEUES*IDX_W-1:0]      next_avail_idx_o,
  output logic [NUM_QUEUES-1:0]            work_avail_o,
  output logic [NUM_QUEUES-1:0]            idx_err_o
);
  localparam int NS = NUM_STAGES;
  localparam int NQ = NUM_QUEUES;
  logic [NS*NQ-1:0] pend_q, pend_d, hs;
  logic [NS*CNT_W-1:0] cnt_q, cnt_d;
  logic [NQ*IDX_W-1:0] shd_q, shd_d, nai_q, nai_d;
  logic [NQ-1:0] err_q, err_d;
  logic [CNT_W:0] acc;
  logic [IDX_W-1:0] od;
  assign pending_o = pend_q;
  assign coalesce_cnt_o = cnt_q;
  assign next_avail_idx_o = nai_q;
  assign idx_err_o = err_q;
  // decode which (stage, queue) completes a handshake this cycle
  always_comb begin
    hs = '0;
    for (int s = 0; s < NS; s++)
      for (int q = 0; q < NQ; q++)
        hs[s*NQ+q] = evt_valid_o[s] & evt_ready_i[s] & (evt_qid_o[s*QID_W +: QID_W] == QID_W'(q));
  end
  // set beats handshake clear; a set that lands on a still-pending flag is counted as coalesced
  always_comb begin
    pend_d = pend_q;
    cnt_d = cnt_q;
    acc = '0;
    for (int s = 0; s < NS; s++) begin
      acc = {1'b0, cnt_q[s*CNT_W +: CNT_W]};
      for (int q = 0; q < NQ; q++) begin
        pend_d[s*NQ+q] = set_i[s*NQ+q] | (pend_q[s*NQ+q] & ~hs[s*NQ+q]);
        acc = acc + {{CNT_W{1'b0}}, set_i[s*NQ+q] & pend_q[s*NQ+q] & ~hs[s*NQ+q]};
      end
      cnt_d[s*CNT_W +: CNT_W] = acc[CNT_W] ? '1 : acc[CNT_W-1:0];
    end
  end
  // shadow writes, consume advance and sticky overrun; out-of-range qids never match a queue
  always_comb begin
    shd_d = shd_q;
    nai_d = nai_q;
    err_d = err_q;
    work_avail_o = '0;
    od = '0;
    for (int q = 0; q < NQ; q++) begin
      if (avail_idx_we_i && avail_idx_qid_i == QID_W'(q)) shd_d[q*IDX_W +: IDX_W] = avail_idx_i;
      nai_d[q*IDX_W +: IDX_W] = nai_q[q*IDX_W +: IDX_W] + IDX_W'(consume_i && consume_qid_i == QID_W'(q));
      od = shd_d[q*IDX_W +: IDX_W] - nai_d[q*IDX_W +: IDX_W];
      err_d[q] = err_q[q] | (od > IDX_W'(Q_SIZE));
      work_avail_o[q] = shd_q[q*IDX_W +: IDX_W] != nai_q[q*IDX_W +: IDX_W];
    end
  end
  // state registers
  always_ff @(posedge clk or negedge csr_rst_n) begin
    if (!csr_rst_n) begin
      pend_q <= '0;
      cnt_q <= '0;
      shd_q <= '0;
      nai_q <= '0;
      err_q <= '0;
    end else if (soft_clr) begin
      pend_q <= '0;
      cnt_q <= '0;
      shd_q <= '0;
      nai_q <= '0;
      err_q <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      shd_q <= shd_d;
      nai_q <= nai_d;
      err_q <= err_d;
    end
  end
  for (genvar s = 0; s < NS; s++) begin : g_stg
    vq_rr_arb #(.NQ(NQ), .QW(QID_W)) u_arb (
      .clk(clk),
      .rst_n(csr_rst_n),
      .soft_clr(soft_clr),
      .pend_nxt_i(pend_d[s*NQ +: NQ]),
      .ready_i(evt_ready_i[s]),
      .valid_o(evt_valid_o[s]),
      .qid_o(evt_qid_o[s*QID_W +: QID_W])
    );
  end
endmodule
